// File: rtl/axil_ls_responder_if.sv
// AXI-Lite style bus bundle for the low-speed register responder (no write-response channel).
interface axil_ls_responder_if #(
  parameter int ADDR_W = 15
);
  logic              axi_ls_awvalid;
  logic [ADDR_W-1:0] axi_ls_awaddr;
  logic              axi_ls_awready;
  logic              axi_ls_wvalid;
  logic [31:0]       axi_ls_wdata;
  logic [3:0]        axi_ls_wstrb;
  logic              axi_ls_wready;
  logic              axi_ls_arvalid;
  logic [ADDR_W-1:0] axi_ls_araddr;
  logic              axi_ls_arready;
  logic              axi_ls_rvalid;
  logic [31:0]       axi_ls_rdata;
  logic              axi_ls_rready;

  modport master (
    output axi_ls_awvalid, axi_ls_awaddr, axi_ls_wvalid, axi_ls_wdata, axi_ls_wstrb,
           axi_ls_arvalid, axi_ls_araddr, axi_ls_rready,
    input  axi_ls_awready, axi_ls_wready, axi_ls_arready, axi_ls_rvalid, axi_ls_rdata
  );

  modport slave (
    input  axi_ls_awvalid, axi_ls_awaddr, axi_ls_wvalid, axi_ls_wdata, axi_ls_wstrb,
           axi_ls_arvalid, axi_ls_araddr, axi_ls_rready,
    output axi_ls_awready, axi_ls_wready, axi_ls_arready, axi_ls_rvalid, axi_ls_rdata
  );
endinterface

// File: rtl/axil_ls_responder.sv
// Low-speed AXI-Lite register responder: one-entry AW/W buffers, commit strobe, 1-deep read FSM.
//   state  | meaning
//   R_IDLE | ready to accept a read address
//   R_DATA | rvalid/rdata held until rready
module axil_ls_responder #(
  parameter  int NREG   = 16,
  parameter  int ADDR_W = 15,
  localparam int IDX_W  = $clog2(NREG)
) (
  input  logic             axi_ls_aclk,
  input  logic             axi_ls_aresetn,
  input  logic             cc_aa_enable,
  axil_ls_responder_if.slave axi,
  output logic             wr_evt,
  output logic [IDX_W-1:0] wr_idx
);
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  r_state_t         r_state;
  logic             aw_full, w_full, aw_oor;
  logic [IDX_W-1:0] aw_idx;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic [31:0]      regs [NREG];
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  logic             aw_hs, w_hs, ar_hs, ar_in_range, unused_addr_bits;
  logic [IDX_W-1:0] ar_idx;

  // Readies are held low throughout reset so nothing is accepted on the release edge's predecessor.
  assign axi.axi_ls_awready = axi_ls_aresetn && cc_aa_enable && !aw_full;
  assign axi.axi_ls_wready  = axi_ls_aresetn && cc_aa_enable && !w_full;
  assign axi.axi_ls_arready = axi_ls_aresetn && cc_aa_enable && (r_state == R_IDLE);
  assign axi.axi_ls_rvalid  = rvalid_q;
  assign axi.axi_ls_rdata   = rdata_q;

  assign aw_hs       = axi.axi_ls_awvalid && axi.axi_ls_awready;
  assign w_hs        = axi.axi_ls_wvalid  && axi.axi_ls_wready;
  assign ar_hs       = axi.axi_ls_arvalid && axi.axi_ls_arready;
  assign ar_idx      = axi.axi_ls_araddr[IDX_W+1:2];
  assign ar_in_range = (axi.axi_ls_araddr[ADDR_W-1:IDX_W+2] == '0);
  assign unused_addr_bits = ^{axi.axi_ls_awaddr[1:0], axi.axi_ls_araddr[1:0]};

  always_ff @(posedge axi_ls_aclk) begin
    if (!axi_ls_aresetn) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_oor  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      wr_evt  <= 1'b0;
      wr_idx  <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      wr_evt <= 1'b0;
      if (aw_full && w_full) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        if (!aw_oor) begin
          for (int b = 0; b < 4; b++)
            if (w_strb[b]) regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
          wr_evt <= 1'b1;
          wr_idx <= aw_idx;
        end
      end else begin
        if (aw_hs) begin
          aw_full <= 1'b1;
          aw_idx  <= axi.axi_ls_awaddr[IDX_W+1:2];
          aw_oor  <= (axi.axi_ls_awaddr[ADDR_W-1:IDX_W+2] != '0);
        end
        if (w_hs) begin
          w_full <= 1'b1;
          w_data <= axi.axi_ls_wdata;
          w_strb <= axi.axi_ls_wstrb;
        end
      end
    end
  end

  // regs is sampled before any same-edge commit lands, so a colliding read returns the old value.
  always_ff @(posedge axi_ls_aclk) begin
    if (!axi_ls_aresetn) begin
      r_state  <= R_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_hs) begin
          r_state  <= R_DATA;
          rvalid_q <= 1'b1;
          rdata_q  <= ar_in_range ? regs[ar_idx] : 32'h0;
        end
        R_DATA: if (axi.axi_ls_rready) begin
          r_state  <= R_IDLE;
          rvalid_q <= 1'b0;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_ls_responder.sv
// Directed self-checking bench for axil_ls_responder (NREG=16, ADDR_W=15).
module tb_axil_ls_responder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       wr_evt;
  logic [3:0] wr_idx;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [31:0] d;

  axil_ls_responder_if #(.ADDR_W(15)) bus ();

  axil_ls_responder #(.NREG(16), .ADDR_W(15)) dut (
    .axi_ls_aclk    (clk),
    .axi_ls_aresetn (rst_n),
    .cc_aa_enable   (en),
    .axi            (bus),
    .wr_evt         (wr_evt),
    .wr_idx         (wr_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rdys();
    return {29'd0, bus.axi_ls_awready, bus.axi_ls_wready, bus.axi_ls_arready};
  endfunction

  task automatic send(input bit do_aw, input bit do_w, input logic [14:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input string tag);
    bit aw_done, w_done, aw_hs, w_hs;
    aw_done = !do_aw;
    w_done  = !do_w;
    bus.axi_ls_awvalid = do_aw;
    bus.axi_ls_awaddr  = addr;
    bus.axi_ls_wvalid  = do_w;
    bus.axi_ls_wdata   = data;
    bus.axi_ls_wstrb   = strb;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      @(negedge clk);
      aw_hs = bus.axi_ls_awvalid && bus.axi_ls_awready;
      w_hs  = bus.axi_ls_wvalid && bus.axi_ls_wready;
      tick();
      if (aw_hs) begin bus.axi_ls_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin bus.axi_ls_wvalid  = 1'b0; w_done  = 1'b1; end
    end
    if (!(aw_done && w_done)) chk({tag, "_timeout"}, 32'd0, 32'd1);
    bus.axi_ls_awvalid = 1'b0;
    bus.axi_ls_wvalid  = 1'b0;
  endtask

  task automatic ar_handshake(input logic [14:0] addr, input string tag);
    bit hs, done;
    done = 1'b0;
    bus.axi_ls_arvalid = 1'b1;
    bus.axi_ls_araddr  = addr;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      hs = bus.axi_ls_arvalid && bus.axi_ls_arready;
      tick();
      if (hs) done = 1'b1;
    end
    bus.axi_ls_arvalid = 1'b0;
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_read(input logic [14:0] addr, output logic [31:0] data, input string tag);
    ar_handshake(addr, tag);
    chk({tag, "_rvalid"}, {31'd0, bus.axi_ls_rvalid}, 32'd1);
    data = bus.axi_ls_rdata;
    bus.axi_ls_rready = 1'b1;
    tick();
    bus.axi_ls_rready = 1'b0;
    chk({tag, "_rdone"}, {31'd0, bus.axi_ls_rvalid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    bus.axi_ls_awvalid = 1'b0; bus.axi_ls_awaddr = '0;
    bus.axi_ls_wvalid  = 1'b0; bus.axi_ls_wdata  = '0; bus.axi_ls_wstrb = '0;
    bus.axi_ls_arvalid = 1'b0; bus.axi_ls_araddr = '0;
    bus.axi_ls_rready  = 1'b0;

    // reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_rdys", rdys(), 32'd0);
    chk("rst_rvalid", {31'd0, bus.axi_ls_rvalid}, 32'd0);
    chk("rst_wr_evt", {31'd0, wr_evt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdys", rdys(), 32'd7);
    tick();

    // same-cycle AW+W
    send(1, 1, 15'h0008, 32'hDEADBEEF, 4'hF, "t1_wr");
    chk("t1_pre_evt", {31'd0, wr_evt}, 32'd0);
    chk("t1_full", rdys(), 32'd1);
    tick();
    chk("t1_evt", {31'd0, wr_evt}, 32'd1);
    chk("t1_idx", {28'd0, wr_idx}, 32'd2);
    chk("t1_rdy_back", rdys(), 32'd7);
    tick();
    chk("t1_pulse", {31'd0, wr_evt}, 32'd0);
    do_read(15'h0008, d, "t1_rd");
    chk("t1_rdata", d, 32'hDEADBEEF);

    // W first, AW three cycles later, partial strobe
    send(1, 1, 15'h0004, 32'hAABBCCDD, 4'hF, "t2_init");
    tick();
    send(0, 1, 15'h0000, 32'h11223344, 4'h5, "t2_w");
    repeat (3) begin
      chk("t2_wready_low", {31'd0, bus.axi_ls_wready}, 32'd0);
      chk("t2_no_evt", {31'd0, wr_evt}, 32'd0);
      tick();
    end
    send(1, 0, 15'h0004, 32'h0, 4'h0, "t2_aw");
    tick();
    chk("t2_evt", {31'd0, wr_evt}, 32'd1);
    chk("t2_idx", {28'd0, wr_idx}, 32'd1);
    do_read(15'h0004, d, "t2_rd");
    chk("t2_rdata", d, 32'hAA22CC44);

    // out-of-range write
    send(1, 1, 15'h0100, 32'h55555555, 4'hF, "t3_wr");
    tick();
    chk("t3_no_evt", {31'd0, wr_evt}, 32'd0);
    chk("t3_rdy_back", rdys(), 32'd7);
    do_read(15'h0100, d, "t3_rd_oor");
    chk("t3_rdata_oor", d, 32'h0);
    do_read(15'h0008, d, "t3_rd8");
    chk("t3_reg2_kept", d, 32'hDEADBEEF);
    do_read(15'h0004, d, "t3_rd4");
    chk("t3_reg1_kept", d, 32'hAA22CC44);

    // rready held low
    send(1, 1, 15'h0000, 32'hCAFEF00D, 4'hF, "t4_wr");
    tick();
    ar_handshake(15'h0000, "t4_ar");
    repeat (5) begin
      chk("t4_rvalid_hold", {31'd0, bus.axi_ls_rvalid}, 32'd1);
      chk("t4_rdata_hold", bus.axi_ls_rdata, 32'hCAFEF00D);
      chk("t4_arready_low", {31'd0, bus.axi_ls_arready}, 32'd0);
      tick();
    end
    bus.axi_ls_rready = 1'b1;
    tick();
    bus.axi_ls_rready = 1'b0;
    chk("t4_rvalid_drop", {31'd0, bus.axi_ls_rvalid}, 32'd0);
    chk("t4_idle", {31'd0, bus.axi_ls_arready}, 32'd1);

    // enable gating with all valids high
    en = 1'b0;
    bus.axi_ls_awvalid = 1'b1; bus.axi_ls_awaddr = 15'h000C;
    bus.axi_ls_wvalid  = 1'b1; bus.axi_ls_wdata  = 32'h0BADCAFE; bus.axi_ls_wstrb = 4'hF;
    bus.axi_ls_arvalid = 1'b1; bus.axi_ls_araddr = 15'h0008;
    repeat (10) begin
      @(negedge clk);
      chk("t5_no_ready", rdys(), 32'd0);
    end
    @(posedge clk); #1;
    en = 1'b1;
    @(negedge clk);
    chk("t5_ready", rdys(), 32'd7);
    @(posedge clk); #1;
    bus.axi_ls_awvalid = 1'b0;
    bus.axi_ls_wvalid  = 1'b0;
    bus.axi_ls_arvalid = 1'b0;
    chk("t5_rvalid", {31'd0, bus.axi_ls_rvalid}, 32'd1);
    chk("t5_rdata", bus.axi_ls_rdata, 32'hDEADBEEF);
    chk("t5_pre_evt", {31'd0, wr_evt}, 32'd0);
    tick();
    chk("t5_evt", {31'd0, wr_evt}, 32'd1);
    chk("t5_idx", {28'd0, wr_idx}, 32'd3);
    bus.axi_ls_rready = 1'b1;
    tick();
    bus.axi_ls_rready = 1'b0;
    do_read(15'h000C, d, "t5_rd");
    chk("t5_reg3", d, 32'h0BADCAFE);

    // pending commit completes after enable drops
    send(1, 1, 15'h0014, 32'h600DF00D, 4'hF, "t5b_wr");
    en = 1'b0;
    tick();
    chk("t5b_evt", {31'd0, wr_evt}, 32'd1);
    chk("t5b_idx", {28'd0, wr_idx}, 32'd5);
    en = 1'b1;

    // reset with AW buffered, W empty
    send(1, 0, 15'h0010, 32'h0, 4'h0, "t6_aw");
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_rdys", rdys(), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rel_rdys", rdys(), 32'd7);
    repeat (3) begin
      tick();
      chk("t6_no_evt", {31'd0, wr_evt}, 32'd0);
    end
    for (int a = 0; a < 6; a++) begin
      do_read(15'(a * 4), d, "t6_rd");
      chk("t6_reg_zero", d, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
